// File: rtl/hit_arbiter.sv
// Hit arbiter for a two-tank game.
// Each bullet's overlaps with walls, the opposing tank and the other bullet are collected
// per frame. On the frame_end_i edge they are evaluated, which produces one-cycle
// bullet-collided pulses and drives two independent per-tank life FSMs
// (alive / dead / invulnerable / out). Those FSMs also track lives and scores.
//
// Ports
//   clk_i, reset_ni                    pixel clock, async active-low reset
//   tankN_enable_i, bulletN_enable_i   current pixel inside tank N / bullet N
//   wall_i                             current pixel is a solid wall
//   frame_end_i                        pulse on last active pixel of a frame
//   one_sec_tick_i                     pulse once per second
//   bulletN_collide_o                  one-cycle pulse, cycle after evaluation
//   tankN_die_o                        tank is dead or out
//   tankN_revive_o                     one-cycle revive pulse
//   tankN_lives_o, scoreN_o            remaining lives, kills scored
//   game_over_o, winner_o              a tank is out / index of the survivor
module hit_arbiter #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned RESPAWN_SECS = 3,
  parameter int unsigned INVULN_SECS  = 2
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       tank0_enable_i,
  input  logic       tank1_enable_i,
  input  logic       bullet0_enable_i,
  input  logic       bullet1_enable_i,
  input  logic       wall_i,
  input  logic       frame_end_i,
  input  logic       one_sec_tick_i,
  output logic       bullet0_collide_o,
  output logic       bullet1_collide_o,
  output logic       tank0_die_o,
  output logic       tank1_die_o,
  output logic       tank0_revive_o,
  output logic       tank1_revive_o,
  output logic [1:0] tank0_lives_o,
  output logic [1:0] tank1_lives_o,
  output logic [3:0] score0_o,
  output logic [3:0] score1_o,
  output logic       game_over_o,
  output logic       winner_o
);

  typedef enum logic [1:0] {StAlive, StDead, StInvuln, StOut} tank_state_e;

  localparam logic [1:0] LivesInit  = 2'(LIVES_INIT);
  localparam logic [3:0] RespawnCnt = 4'(RESPAWN_SECS);
  localparam logic [3:0] InvulnCnt  = 4'(INVULN_SECS);

  // Sticky per-frame overlap flags
  logic b0_wall_q, b1_wall_q, b0_t1_q, b1_t0_q, bb_q;
  logic b0_wall_d, b1_wall_d, b0_t1_d, b1_t0_d, bb_d;

  // Flags including the current pixel, so the frame_end_i pixel itself counts
  logic b0_wall_seen, b1_wall_seen, b0_t1_seen, b1_t0_seen, bb_seen;

  assign b0_wall_seen = b0_wall_q | (bullet0_enable_i & wall_i);
  assign b1_wall_seen = b1_wall_q | (bullet1_enable_i & wall_i);
  assign b0_t1_seen   = b0_t1_q   | (bullet0_enable_i & tank1_enable_i);
  assign b1_t0_seen   = b1_t0_q   | (bullet1_enable_i & tank0_enable_i);
  assign bb_seen      = bb_q      | (bullet0_enable_i & bullet1_enable_i);

  always_comb begin
    b0_wall_d = b0_wall_seen;
    b1_wall_d = b1_wall_seen;
    b0_t1_d   = b0_t1_seen;
    b1_t0_d   = b1_t0_seen;
    bb_d      = bb_seen;
    if (frame_end_i) begin
      b0_wall_d = 1'b0;
      b1_wall_d = 1'b0;
      b0_t1_d   = 1'b0;
      b1_t0_d   = 1'b0;
      bb_d      = 1'b0;
    end
  end

  logic [1:0] collide_d, collide_q;
  logic [1:0] hit;   // hit[i]: tank i was struck by the opposing bullet this frame
  logic [1:0] kill;  // kill[i]: tank i scores a kill on this edge

  assign collide_d[0] = frame_end_i & (b0_wall_seen | b0_t1_seen | bb_seen);
  assign collide_d[1] = frame_end_i & (b1_wall_seen | b1_t0_seen | bb_seen);
  assign hit[0]       = frame_end_i & b1_t0_seen;
  assign hit[1]       = frame_end_i & b0_t1_seen;

  tank_state_e state_q [2];
  tank_state_e state_d [2];
  logic [3:0]  cnt_q   [2];
  logic [3:0]  cnt_d   [2];
  logic [1:0]  lives_q [2];
  logic [1:0]  lives_d [2];
  logic [3:0]  score_q [2];
  logic [3:0]  score_d [2];
  logic [1:0]  revive_q, revive_d;

  // Only a hit on an ALIVE tank is a kill
  assign kill[0] = hit[1] & (state_q[1] == StAlive);
  assign kill[1] = hit[0] & (state_q[0] == StAlive);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      lives_d[i]  = lives_q[i];
      score_d[i]  = score_q[i];
      revive_d[i] = 1'b0;

      // Loading the counter takes priority, so a coincident tick is dropped
      unique case (state_q[i])
        StAlive: begin
          if (hit[i]) begin
            state_d[i] = StDead;
            cnt_d[i]   = RespawnCnt;
            if (lives_q[i] != 2'd0) lives_d[i] = lives_q[i] - 2'd1;
          end
        end
        StDead: begin
          if (one_sec_tick_i) begin
            if (cnt_q[i] <= 4'd1) begin
              if (lives_q[i] != 2'd0) begin
                state_d[i]  = StInvuln;
                cnt_d[i]    = InvulnCnt;
                revive_d[i] = 1'b1;
              end else begin
                state_d[i] = StOut;
                cnt_d[i]   = 4'd0;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - 4'd1;
            end
          end
        end
        StInvuln: begin
          if (one_sec_tick_i) begin
            if (cnt_q[i] <= 4'd1) begin
              state_d[i] = StAlive;
              cnt_d[i]   = 4'd0;
            end else begin
              cnt_d[i] = cnt_q[i] - 4'd1;
            end
          end
        end
        StOut: begin
          state_d[i] = StOut;
        end
      endcase

      if (kill[i] && (score_q[i] != 4'd15)) score_d[i] = score_q[i] + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      b0_wall_q <= 1'b0;
      b1_wall_q <= 1'b0;
      b0_t1_q   <= 1'b0;
      b1_t0_q   <= 1'b0;
      bb_q      <= 1'b0;
      collide_q <= 2'b00;
      revive_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StAlive;
        cnt_q[i]   <= 4'd0;
        lives_q[i] <= LivesInit;
        score_q[i] <= 4'd0;
      end
    end else begin
      b0_wall_q <= b0_wall_d;
      b1_wall_q <= b1_wall_d;
      b0_t1_q   <= b0_t1_d;
      b1_t0_q   <= b1_t0_d;
      bb_q      <= bb_d;
      collide_q <= collide_d;
      revive_q  <= revive_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        lives_q[i] <= lives_d[i];
        score_q[i] <= score_d[i];
      end
    end
  end

  logic out0, out1;
  assign out0 = (state_q[0] == StOut);
  assign out1 = (state_q[1] == StOut);

  assign bullet0_collide_o = collide_q[0];
  assign bullet1_collide_o = collide_q[1];
  assign tank0_die_o       = (state_q[0] == StDead) | out0;
  assign tank1_die_o       = (state_q[1] == StDead) | out1;
  assign tank0_revive_o    = revive_q[0];
  assign tank1_revive_o    = revive_q[1];
  assign tank0_lives_o     = lives_q[0];
  assign tank1_lives_o     = lives_q[1];
  assign score0_o          = score_q[0];
  assign score1_o          = score_q[1];
  assign game_over_o       = out0 | out1;
  assign winner_o          = out0 & ~out1;

endmodule

// File: doc/hit_arbiter.md
HIT_ARBITER -- requirements
Module: hit_arbiter

Interface
REQ-001 SHALL provide parameter LIVES_INIT, default 3, giving lives per tank after reset (range 1-3).
REQ-002 SHALL provide parameter RESPAWN_SECS, default 3, giving the dead time in one-second ticks (range 1-15).
REQ-003 SHALL provide parameter INVULN_SECS, default 2, giving the post-revive invulnerable time in one-second ticks (range 1-15).
REQ-004 SHALL have the following ports:
- clk_i, input, 1 bit: pixel clock; the only clock.
- reset_ni, input, 1 bit: asynchronous active-low reset.
- tank0_enable_i / tank1_enable_i, input, 1 bit each: current pixel lies inside that tank's box.
- bullet0_enable_i / bullet1_enable_i, input, 1 bit each: current pixel lies inside that tank's bullet.
- wall_i, input, 1 bit: current pixel is a solid wall.
- frame_end_i, input, 1 bit: single-cycle pulse on the last active pixel of a frame.
- one_sec_tick_i, input, 1 bit: single-cycle pulse once per second.
- bullet0_collide_o / bullet1_collide_o, output, 1 bit each: bullet-collided pulse returned to that tank.
- tank0_die_o / tank1_die_o, output, 1 bit each: tank is dead or out (level).
- tank0_revive_o / tank1_revive_o, output, 1 bit each: single-cycle revive pulse.
- tank0_lives_o / tank1_lives_o, output, 2 bits each: remaining lives.
- score0_o / score1_o, output, 4 bits each: kills scored by that tank.
- game_over_o, output, 1 bit: at least one tank is OUT.
- winner_o, output, 1 bit: index of the surviving tank; meaningful only while game_over_o = 1.

Function
REQ-005 SHALL keep the following sticky per-frame flags, set on any clk_i cycle where the condition holds, including the frame_end_i cycle:
- b0_wall = bullet0 & wall; b1_wall = bullet1 & wall.
- b0_t1 = bullet0 & tank1; b1_t0 = bullet1 & tank0.
- bb = bullet0 & bullet1.
REQ-006 SHALL ignore self-overlap: bullet0 & tank0 and bullet1 & tank1 set no flag.
REQ-007 SHALL evaluate the flags, including the frame_end_i cycle's pixel, on the clk_i edge where frame_end_i = 1, and clear all flags on that same edge.
REQ-008 SHALL pulse bullet0_collide_o for exactly one cycle, the cycle after evaluation, when any of b0_wall, b0_t1 or bb is set; bullet1_collide_o likewise from b1_wall, b1_t0 or bb.
REQ-009 SHALL run an independent per-tank FSM with states ALIVE, DEAD, INVULN and OUT, plus a 4-bit countdown counter.
REQ-010 SHALL, when a tank is ALIVE and the opponent's hit flag is set at evaluation:
- move the tank to DEAD and decrement its lives;
- increment the opponent's score;
- load the counter with RESPAWN_SECS.
All of these SHALL take effect on the evaluation edge.
REQ-011 SHALL, in DEAD, decrement the counter on each one_sec_tick_i. When the counter would reach 0:
- if lives > 0, pulse revive for one cycle, enter INVULN and load INVULN_SECS;
- if lives = 0, enter OUT.
REQ-012 SHALL, in INVULN, still count the bullet as collided (REQ-008) but apply no death, life or score change; the counter decrements on one_sec_tick_i, and reaching 0 returns the tank to ALIVE.
REQ-013 SHALL hold OUT until reset; hits on an OUT tank are ignored.
REQ-014 SHALL drive tankN_die_o = 1 exactly in DEAD or OUT.
REQ-015 SHALL ignore a one_sec_tick_i that coincides with the edge on which the counter is loaded.
REQ-016 SHALL, when both tanks are hit in the same frame, kill both and increment both scores.
REQ-017 SHALL saturate scores at 15; lives never go below 0.
REQ-018 SHALL drive game_over_o = 1 while either tank is OUT, with winner_o = 1 if tank0 is OUT, else 0; if both are OUT, winner_o = 0.
REQ-019 SHALL, when frame_end_i and one_sec_tick_i coincide, apply the hit evaluation first; a tank that dies on that edge loads its counter and ignores the tick.

Reset
REQ-020 SHALL, while reset_ni = 0 (asynchronously):
- clear all flags, pulses and counters;
- put both FSMs in ALIVE;
- set lives = LIVES_INIT and scores = 0;
- drive die, revive, game_over_o and winner_o to 0.
REQ-021 SHALL, on reset assertion mid-countdown or mid-frame, discard all pending state; no collide or revive pulse is emitted after release until a new evaluation occurs.

Verification
REQ-022 Bullet0 overlaps wall for 3 pixels, then frame_end -> one bullet0_collide_o pulse the cycle after frame_end; no die, score or lives change.
REQ-023 Bullet0 overlaps tank1 (ALIVE), then frame_end -> bullet0_collide_o pulse; tank1_die_o = 1; tank1_lives_o 3 -> 2; score0_o 0 -> 1; after 3 ticks, tank1_revive_o pulses once and tank1_die_o = 0.
REQ-024 Bullet1 overlaps tank0 during tank0 INVULN -> bullet1_collide_o pulse; tank0 lives and score1_o unchanged; tank0 returns to ALIVE after 2 ticks.
REQ-025 Both bullets hit opposite tanks and overlap each other in one frame -> both collide pulses; both tanks DEAD; score0_o = score1_o = 1.
REQ-026 Tank1 killed three times (LIVES_INIT = 3) -> after the third RESPAWN_SECS countdown, tank1 enters OUT with no revive pulse; game_over_o = 1, winner_o = 0; tank1_die_o stays 1 until reset_ni low, which restores lives to 3 and scores to 0.
